// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone load/store initiator.
package wb_pkg;

  // Access size as encoded on req_size.
  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  // Initiator FSM states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRd     = 3'd1,
    StWr     = 3'd2,
    StRmwRd  = 3'd3,
    StRmwGap = 3'd4,
    StRmwWr  = 3'd5,
    StResp   = 3'd6
  } state_e;

  // True when the request can never be issued on the bus: a misaligned half or word,
  // or the illegal size encoding.
  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/WB4.sv
// Wishbone B4 classic bus bundle (32-bit data, word addressed, no byte selects).
interface WB4;
  logic [31:0] ADR;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        WE;
  logic        STB;
  logic        CYC;
  logic        ACK;

  modport master (
    output ADR, DAT_O, WE, STB, CYC,
    input  DAT_I, ACK
  );

  modport slave (
    input  ADR, DAT_O, WE, STB, CYC,
    output DAT_I, ACK
  );
endinterface

// File: rtl/wb_lane_align.sv
// Byte-lane steering: extracts and extends load data from a bus word, and merges
// sub-word store data into a previously read bus word.
module wb_lane_align
  import wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic [31:0] merged_word
);

  logic [31:0] shifted;

  // Load path: bring the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    shifted   = word >> {addr, 3'b000};
    rdata_ext = word;
    case (size)
      SIZE_B:  rdata_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_H:  rdata_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: rdata_ext = word;
    endcase
  end

  // Store path: overwrite only the addressed byte or half of the read word.
  always_comb begin
    merged_word = word;
    case (size)
      SIZE_B:  merged_word[{addr, 3'b000} +: 8]     = wdata[7:0];
      SIZE_H:  merged_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/wb_mem_master.sv
// Wishbone classic initiator for the core load/store port. One request at a time,
// sub-word stores done as a locked read-modify-write, and a no-ACK timeout.
module wb_mem_master
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  WB4.master          wb
);

  // A disabled timeout still needs a legal one-bit counter.
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Count value in the last permitted STB cycle; STB is high exactly TIMEOUT_CYCLES cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic            we_q, we_d;
  size_e           size_q, size_d;
  logic            uns_q, uns_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdat_q, rdat_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic        strobe;
  logic        to_hit;
  logic [31:0] rdata_ext;
  logic [31:0] merged_word;

  assign strobe = (state_q == StRd) || (state_q == StWr) ||
                  (state_q == StRmwRd) || (state_q == StRmwWr);
  assign to_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST);

  // The merged store word is a pure function of the captured read word, so it is
  // settled during the gap cycle and held stable through the write strobe.
  wb_lane_align u_lane_align (
    .word        (rdat_q),
    .addr        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata_ext   (rdata_ext),
    .merged_word (merged_word)
  );

  // Next-state: request latch, ACK handling and timeout abort.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdat_d   = rdat_q;
    err_d    = err_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = size_e'(req_size);
          uns_d    = req_unsigned;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = misaligned(size_e'(req_size), req_addr[1:0]);
          to_cnt_d = '0;
          if (err_d) begin
            state_d = StResp;
          end else if (!req_we) begin
            state_d = StRd;
          end else if (size_e'(req_size) == SIZE_W) begin
            state_d = StWr;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StRd, StWr, StRmwRd, StRmwWr: begin
        // ACK beats a simultaneous timeout expiry.
        if (wb.ACK) begin
          if ((state_q == StRd) || (state_q == StRmwRd)) begin
            rdat_d = wb.DAT_I;
          end
          state_d = (state_q == StRmwRd) ? StRmwGap : StResp;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StRmwGap: begin
        // Bus stays locked; a held ACK from the read is absorbed here.
        to_cnt_d = '0;
        state_d  = StRmwWr;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      size_q   <= SIZE_B;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdat_q   <= '0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdat_q   <= rdat_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign wb.CYC   = strobe || (state_q == StRmwGap);
  assign wb.STB   = strobe;
  assign wb.WE    = (state_q == StWr) || (state_q == StRmwWr);
  assign wb.ADR   = {2'b00, addr_q[31:2]};
  assign wb.DAT_O = (state_q == StRmwWr) ? merged_word : wdata_q;

  // Response outputs are decoded straight from the state, so RESP lasts one cycle.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_err   = (state_q == StResp) && err_q;
    resp_rdata = ((state_q == StResp) && !err_q && !we_q) ? rdata_ext : '0;
  end

endmodule

// File: tb/tb_wb_mem_master.sv
// Self-checking bench for wb_mem_master: directed scenarios plus randomized
// loads/stores compared against a byte-array memory model.
module tb_wb_mem_master;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  WB4 wb ();

  wb_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .wb           (wb)
  );

  // Responder: registered ACK over a 128-word RAM. stale_ack keeps ACK high one
  // cycle after STB falls; no_ack models a missing responder.
  logic [31:0] mem [0:127];
  logic        ack_q = 1'b0;
  logic [31:0] dat_q = '0;
  logic        no_ack = 1'b0;
  logic        stale_ack = 1'b0;
  logic        pre_we = 1'b0;
  logic [6:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    if (wb.CYC && wb.STB && !no_ack && (stale_ack || !ack_q)) begin
      ack_q <= 1'b1;
      if (wb.WE) mem[wb.ADR[6:0]] <= wb.DAT_O;
      else dat_q <= mem[wb.ADR[6:0]];
    end else begin
      ack_q <= 1'b0;
    end
  end

  assign wb.ACK   = ack_q;
  assign wb.DAT_I = dat_q;

  // Bus monitor: free-running event counters sampled on each edge.
  int          stb_cnt = 0;
  int          cyc_cnt = 0;
  int          gap_cnt = 0;
  int          rise_cnt = 0;
  int          resp_cnt = 0;
  logic        cyc_prev = 1'b0;
  logic [31:0] w_adr = '0;
  logic [31:0] w_dat = '0;

  always @(posedge clk) begin
    if (wb.CYC && wb.STB) stb_cnt <= stb_cnt + 1;
    if (wb.CYC) cyc_cnt <= cyc_cnt + 1;
    if (wb.CYC && !wb.STB) gap_cnt <= gap_cnt + 1;
    if (wb.CYC && !cyc_prev) rise_cnt <= rise_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
    if (wb.CYC && wb.STB && wb.WE) begin
      w_adr <= wb.ADR;
      w_dat <= wb.DAT_O;
    end
    cyc_prev <= wb.CYC;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required $finish");
    $fatal(1);
  end

  // Reference model: byte-addressed little-endian memory.
  logic [7:0]  ref_mem [0:511];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_rdata;
  int          d_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_req(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr);
    longint unsigned v = 0;
    int n = 1 << size;
    for (int i = 0; i < n; i++) begin
      v = v | (longint'(ref_mem[int'(addr[8:0]) + i]) << (8 * i));
    end
    if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[idx*4+3], ref_mem[idx*4+2], ref_mem[idx*4+1], ref_mem[idx*4]};
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int n = 1 << size;
    for (int i = 0; i < n; i++) ref_mem[int'(addr[8:0]) + i] = wdata[8*i +: 8];
  endtask

  // Present a request at #1 after an edge and hold it until accepted.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    while (!req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Cycles from the accept edge until resp_valid is seen (1 = very next cycle).
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) check("resp_wait", 32'(resp_valid), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic to_exp);
    int s_stb = stb_cnt, s_cyc = cyc_cnt, s_gap = gap_cnt, s_rise = rise_cnt;
    int s_resp = resp_cnt;
    int lat, exp_lat, exp_stb, exp_gap;
    logic bad = bad_req(size, addr);
    logic rmw = we && (size != 2'd2);
    logic exp_err = bad || to_exp;
    logic [31:0] exp_rd = (we || exp_err) ? 32'd0 : ref_load(size, uns, addr);
    if (bad) begin
      exp_lat = 1; exp_stb = 0; exp_gap = 0;
    end else if (to_exp) begin
      exp_lat = TO + 1; exp_stb = TO; exp_gap = 0;
    end else if (rmw) begin
      exp_lat = 6; exp_stb = 4; exp_gap = 1;
    end else begin
      exp_lat = 3; exp_stb = 2; exp_gap = 0;
    end
    issue(we, size, uns, addr, wdata);
    wait_resp(lat);
    last_rdata = resp_rdata;
    check({tag, "/err"}, 32'(resp_err), 32'(exp_err));
    check({tag, "/rdata"}, resp_rdata, exp_rd);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    check({tag, "/pulse"}, 32'(resp_valid), 32'd0);
    check({tag, "/resp_count"}, 32'(resp_cnt - s_resp), 32'd1);
    check({tag, "/stb_cycles"}, 32'(stb_cnt - s_stb), 32'(exp_stb));
    check({tag, "/gap_cycles"}, 32'(gap_cnt - s_gap), 32'(exp_gap));
    d_cyc = cyc_cnt - s_cyc;
    check({tag, "/cyc_cycles"}, 32'(d_cyc), 32'(exp_stb + exp_gap));
    check({tag, "/cyc_rises"}, 32'(rise_cnt - s_rise), (exp_stb > 0) ? 32'd1 : 32'd0);
    if (we && !exp_err) ref_store(size, addr, wdata);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    @(posedge clk);
    #1;
    // Preload responder RAM and model with the same random contents.
    for (int i = 0; i < 128; i++) begin
      pre_idx = 7'(i);
      pre_val = $urandom;
      pre_we = 1'b1;
      for (int b = 0; b < 4; b++) ref_mem[i*4+b] = pre_val[8*b +: 8];
      @(posedge clk);
      #1;
    end
    pre_we = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset/cyc", 32'(wb.CYC), 32'd0);
    check("reset/stb", 32'(wb.STB), 32'd0);
    check("reset/adr", wb.ADR, 32'd0);
    check("reset/dat_o", wb.DAT_O, 32'd0);
    check("reset/resp_rdata", resp_rdata, 32'd0);

    // Reset held two cycles while idle.
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("idle_rst/cyc", 32'(wb.CYC), 32'd0);
    check("idle_rst/stb", 32'(wb.STB), 32'd0);
    check("idle_rst/we", 32'(wb.WE), 32'd0);
    check("idle_rst/resp_valid", 32'(resp_valid), 32'd0);
    check("idle_rst/resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_rst/req_ready", 32'(req_ready), 32'd1);

    // Word store then load.
    do_op("sw_beef", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0);
    check("sw_beef/adr", w_adr, 32'h40);
    check("sw_beef/dat_o", w_dat, 32'hDEADBEEF);
    check("sw_beef/mem", mem[64], 32'hDEADBEEF);
    do_op("lw_beef", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0);
    check("lw_beef/value", last_rdata, 32'hDEADBEEF);

    // Byte store as RMW with a responder that holds ACK after STB falls.
    do_op("sw_1122", 1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, 1'b0);
    stale_ack = 1'b1;
    do_op("sb_a5", 1'b1, 2'd0, 1'b0, 32'h102, 32'h000000A5, 1'b0);
    stale_ack = 1'b0;
    check("sb_a5/dat_o", w_dat, 32'h11A53344);
    check("sb_a5/mem", mem[64], 32'h11A53344);
    do_op("lb_a5", 1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 1'b0);
    check("lb_a5/value", last_rdata, 32'hFFFFFFA5);
    do_op("lbu_a5", 1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 1'b0);
    check("lbu_a5/value", last_rdata, 32'h000000A5);

    // Misaligned half load: no bus cycle.
    do_op("lh_mis", 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 1'b0);
    do_op("size_ill", 1'b1, 2'd3, 1'b0, 32'h100, 32'h12345678, 1'b0);

    // Missing responder: timeout on a load and on the read half of an RMW.
    no_ack = 1'b1;
    do_op("lw_to", 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 1'b1);
    check("lw_to/cyc_after", 32'(wb.CYC), 32'd0);
    do_op("sh_to", 1'b1, 2'd1, 1'b0, 32'h106, 32'h1234, 1'b1);
    no_ack = 1'b0;
    check("sh_to/mem", mem[65], ref_word(65));

    // Reset during the RMW gap cycle.
    do_op("sw_restore", 1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h55);
    n = 0;
    while (!(wb.CYC && !wb.STB) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_rmw/gap_seen", 32'(wb.CYC && !wb.STB), 32'd1);
    n = resp_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rmw/cyc", 32'(wb.CYC), 32'd0);
    check("rst_rmw/stb", 32'(wb.STB), 32'd0);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("rst_rmw/no_resp", 32'(resp_cnt - n), 32'd0);
    check("rst_rmw/req_ready", 32'(req_ready), 32'd1);
    check("rst_rmw/mem", mem[64], 32'h11223344);
    do_op("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0);
    check("lw_after_rst/value", last_rdata, 32'h11223344);

    // Randomized mix of loads and stores against the model.
    for (int i = 0; i < 60; i++) begin
      logic        we = 1'($urandom_range(0, 1));
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic        un = 1'($urandom_range(0, 1));
      logic [31:0] a = 32'($urandom_range(0, 511));
      logic [31:0] wd = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      do_op($sformatf("rnd%0d", i), we, sz, un, a, wd, 1'b0);
    end
    for (int i = 0; i < 128; i++) begin
      if (mem[i] !== ref_word(i)) check($sformatf("final_mem%0d", i), mem[i], ref_word(i));
    end
    check("final_mem64", mem[64], ref_word(64));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
